// File: rtl/sram_line_engine_pkg.sv
// Shared types and constants for the SRAM line engine.
// Holds the FSM state encoding and line/SRAM geometry defaults.
package sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam int LINE_WORDS        = 4;
  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;
  localparam int DEF_ACCESS_CYCLES = 6;

endpackage

// File: rtl/sram_line_engine_if.sv
// Request/response bundle between cache_controller and the engine.
// master: req_valid/req_we/req_addr/req_wdata out; busy/done/line_data in.
interface sram_line_engine_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) ();

  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  busy;
  logic                  done;
  logic [4*DATA_W-1:0]   line_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  busy, done, line_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output busy, done, line_data
  );

endinterface

// File: rtl/sram_line_engine_wait.sv
// Per-access wait counter: clears on state entry, wraps every access.
// Ports: clk, rst (sync active-low), clear in; last out (c == N-1).
module sram_wait_counter #(
  parameter int ACCESS_CYCLES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int CW =
    (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] c;

  assign last = (c == C_LAST);

  // Wrapping on last lets a read step through four words
  // without leaving RD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c <= '0;
    end else if (clear || last) begin
      c <= '0;
    end else begin
      c <= c + 1'b1;
    end
  end

endmodule

// File: rtl/sram_line_engine.sv
// MEM-stage SRAM back end: 4-word line refills and word write-through.
// Ports: clk, rst (sync active-low), bus (slave), SRAM_* pins.
module sram_line_engine
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  sram_line_engine_if.slave bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_UB_N_O,
  output logic              SRAM_LB_N_O,
  output logic              SRAM_WE_N_O,
  output logic              SRAM_CE_N_O,
  output logic              SRAM_OE_N_O
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [1:0]                 k_q;
  logic [LINE_WORDS*DATA_W-1:0] line_q;
  logic                       last;
  logic                       clear;

  assign clear = (state_q != state_d);

  sram_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .last (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.req_valid)
          state_d = bus.req_we ? S_WR : S_RD;
      S_RD:
        if (last && (k_q == 2'd3))
          state_d = S_DONE;
      S_WR:
        if (last)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    SRAM_UB_N_O = 1'b1;
    SRAM_LB_N_O = 1'b1;
    SRAM_WE_N_O = 1'b1;
    SRAM_CE_N_O = 1'b1;
    SRAM_OE_N_O = 1'b1;
    unique case (state_q)
      S_RD: begin
        SRAM_UB_N_O = 1'b0;
        SRAM_LB_N_O = 1'b0;
        SRAM_CE_N_O = 1'b0;
        SRAM_OE_N_O = 1'b0;
      end
      S_WR: begin
        SRAM_UB_N_O = 1'b0;
        SRAM_LB_N_O = 1'b0;
        SRAM_CE_N_O = 1'b0;
        // High on the final cycle: one cycle of data hold.
        SRAM_WE_N_O = last;
      end
      default: ;
    endcase
  end

  // Word index stays 2-bit so base+3 never carries out of the line.
  assign SRAM_ADDR = (state_q == S_RD) ?
    {addr_q[ADDR_W-1:2], k_q} : addr_q;

  assign SRAM_DQ = (state_q == S_WR) ? wdata_q : 'z;

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.line_data = line_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= 2'd0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE:
          if (bus.req_valid) begin
            k_q <= 2'd0;
            if (bus.req_we) begin
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
            end else begin
              addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        S_RD:
          if (last) begin
            line_q[int'(k_q)*DATA_W +: DATA_W] <= SRAM_DQ;
            k_q <= k_q + 2'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_engine.sv
// Directed bench: default-timing engine (a) and ACCESS_CYCLES=2 engine (b).
// Each has a word SRAM model returning 16'hA000+addr until written.
module tb_sram_line_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_line_engine_if #(.ADDR_W(18), .DATA_W(16)) bus_a ();
  sram_line_engine_if #(.ADDR_W(18), .DATA_W(16)) bus_b ();

  logic [17:0] addr_a, addr_b;
  wire  [15:0] dq_a, dq_b;
  logic ub_a, lb_a, we_a, ce_a, oe_a;
  logic ub_b, lb_b, we_b, ce_b, oe_b;

  sram_line_engine #(.ACCESS_CYCLES(6)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a),
    .SRAM_UB_N_O(ub_a), .SRAM_LB_N_O(lb_a),
    .SRAM_WE_N_O(we_a), .SRAM_CE_N_O(ce_a),
    .SRAM_OE_N_O(oe_a)
  );

  sram_line_engine #(.ACCESS_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b),
    .SRAM_UB_N_O(ub_b), .SRAM_LB_N_O(lb_b),
    .SRAM_WE_N_O(we_b), .SRAM_CE_N_O(ce_b),
    .SRAM_OE_N_O(oe_b)
  );

  bit [15:0] wm_a [0:511];
  bit        wf_a [0:511];
  bit [15:0] wm_b [0:511];
  bit        wf_b [0:511];
  logic [15:0] rd_a, rd_b;

  always_comb begin
    rd_a = 16'hA000 + {7'd0, addr_a[8:0]};
    if (wf_a[addr_a[8:0]]) rd_a = wm_a[addr_a[8:0]];
    rd_b = 16'hA000 + {7'd0, addr_b[8:0]};
    if (wf_b[addr_b[8:0]]) rd_b = wm_b[addr_b[8:0]];
  end

  assign dq_a = (!oe_a && !ce_a && we_a) ? rd_a : 'z;
  assign dq_b = (!oe_b && !ce_b && we_b) ? rd_b : 'z;

  always @(posedge clk) begin
    if (!ce_a && !we_a) begin
      wm_a[addr_a[8:0]] <= dq_a;
      wf_a[addr_a[8:0]] <= 1'b1;
    end
    if (!ce_b && !we_b) begin
      wm_b[addr_b[8:0]] <= dq_b;
      wf_b[addr_b[8:0]] <= 1'b1;
    end
  end

  bit          sel;
  logic        m_done, m_we_n;
  logic [17:0] m_addr;
  logic [15:0] m_dq;
  logic [63:0] m_line;

  always_comb begin
    m_done = sel ? bus_b.done      : bus_a.done;
    m_we_n = sel ? we_b            : we_a;
    m_addr = sel ? addr_b          : addr_a;
    m_dq   = sel ? dq_b            : dq_a;
    m_line = sel ? bus_b.line_data : bus_a.line_data;
  end

  int vecs  = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s, input bit v, input bit we,
                       input logic [17:0] a,
                       input logic [15:0] d);
    if (s) begin
      bus_b.req_valid = v; bus_b.req_we = we;
      bus_b.req_addr  = a; bus_b.req_wdata = d;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we;
      bus_a.req_addr  = a; bus_a.req_wdata = d;
    end
  endtask

  // Called on a negedge with the engine idle.
  task automatic run_req(input bit s, input bit we,
                         input logic [17:0] a,
                         input logic [15:0] d,
                         output int lat, output int welow,
                         output int dqerr, output int aerr);
    int ac;
    logic [1:0]  kk;
    logic [17:0] ea;
    ac = s ? 2 : 6;
    sel = s;
    lat = -1; welow = 0; dqerr = 0; aerr = 0;
    drive(s, 1'b1, we, a, d);
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) drive(s, 1'b0, 1'b0, 18'd0, 16'd0);
      if (m_done) begin
        lat = n;
        break;
      end
      if (!m_we_n) welow++;
      if (we) begin
        if (m_dq !== d) dqerr++;
        if (m_addr !== a) aerr++;
      end else begin
        kk = 2'((n - 1) / ac);
        ea = {a[17:2], kk};
        if (m_addr !== ea) aerr++;
      end
    end
  endtask

  typedef struct {
    bit          s;
    bit          we;
    logic [17:0] addr;
    logic [15:0] wd;
    int          lat;
    int          welow;
    logic [63:0] line;
  } vec_t;

  vec_t tbl [8];

  int lat, welow, dqerr, aerr;
  int nd, d1, d2;

  initial begin
    tbl[0] = '{0, 1, 18'h00010, 16'hBEEF, 7, 5,
               64'h0};
    tbl[1] = '{0, 0, 18'h00106, 16'h0, 25, 0,
               64'hA107_A106_A105_A104};
    tbl[2] = '{0, 0, 18'h00010, 16'h0, 25, 0,
               64'hA013_A012_A011_BEEF};
    tbl[3] = '{0, 1, 18'h001FF, 16'h1234, 7, 5,
               64'hA013_A012_A011_BEEF};
    tbl[4] = '{0, 0, 18'h001FD, 16'h0, 25, 0,
               64'h1234_A1FE_A1FD_A1FC};
    tbl[5] = '{1, 0, 18'h00020, 16'h0, 9, 0,
               64'hA023_A022_A021_A020};
    tbl[6] = '{1, 1, 18'h00021, 16'h5A5A, 3, 1,
               64'hA023_A022_A021_A020};
    tbl[7] = '{1, 0, 18'h00022, 16'h0, 9, 0,
               64'hA023_A022_5A5A_A020};

    // Reset held 3 cycles with a request pending.
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 18'h00100, 16'h0);
    drive(1, 1'b1, 1'b1, 18'h00100, 16'h1111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes",
          {ub_a, lb_a, we_a, ce_a, oe_a}, 64'h1F);
    check("rst_dq_z",
          {48'h0, dq_a === 16'hzzzz}, 64'h1);
    check("rst_busy", bus_a.busy, 64'h0);
    check("rst_done", bus_a.done, 64'h0);
    check("rst_line", bus_a.line_data, 64'h0);
    check("rst_addr", addr_a, 64'h0);
    check("rst_b_strobes",
          {ub_b, lb_b, we_b, ce_b, oe_b}, 64'h1F);
    drive(0, 1'b0, 1'b0, 18'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 18'h0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", bus_a.busy, 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wd,
              lat, welow, dqerr, aerr);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_we_low", i), welow, tbl[i].welow);
      check($sformatf("v%0d_addr_err", i), aerr, 0);
      if (tbl[i].we)
        check($sformatf("v%0d_dq_err", i), dqerr, 0);
      check($sformatf("v%0d_line", i), m_line, tbl[i].line);
      @(negedge clk);
      check($sformatf("v%0d_idle", i),
            sel ? bus_b.busy : bus_a.busy, 0);
    end

    // Write, then read on the cycle after DONE, stray strobe in RD.
    sel = 0;
    nd = 0; d1 = 0; d2 = 0;
    drive(0, 1'b1, 1'b1, 18'h00030, 16'hCAFE);
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus_a.done) begin
        nd++;
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
      drive(0, 1'b0, 1'b0, 18'h0, 16'h0);
      if (d1 != 0 && n == d1 + 1)
        drive(0, 1'b1, 1'b0, 18'h00104, 16'h0);
      if (d1 != 0 && n == d1 + 6)
        drive(0, 1'b1, 1'b1, 18'h00104, 16'hDEAD);
    end
    check("b2b_done_count", nd, 2);
    check("b2b_first_done", d1, 7);
    check("b2b_second_done", d2, 33);
    check("b2b_line", bus_a.line_data,
          64'hA107_A106_A105_A104);

    // Reset in cycle 10 of a read.
    nd = 0;
    drive(0, 1'b1, 1'b0, 18'h00108, 16'h0);
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) drive(0, 1'b0, 1'b0, 18'h0, 16'h0);
      if (bus_a.done) nd++;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_no_done", nd, 0);
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_done", bus_a.done, 0);
    check("midrst_line", bus_a.line_data, 0);
    check("midrst_strobes",
          {ub_a, lb_a, we_a, ce_a, oe_a}, 64'h1F);
    check("midrst_dq_z",
          {48'h0, dq_a === 16'hzzzz}, 64'h1);
    @(negedge clk);
    run_req(0, 1'b0, 18'h0010C, 16'h0,
            lat, welow, dqerr, aerr);
    check("after_rst_latency", lat, 25);
    check("after_rst_addr_err", aerr, 0);
    check("after_rst_line", bus_a.line_data,
          64'hA10F_A10E_A10D_A10C);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule

// File: doc/sram_line_engine.md
# sram_line_engine

Memory-side back end of the MEM stage. Sits directly downstream of `cache_controller` and owns the external SRAM pins. Services two request types:
- 4-word (64-bit) line refills on a cache miss;
- single-word write-through stores.

Each SRAM access is stretched over a fixed number of clock cycles.

## Interface
Parameters:
- `ACCESS_CYCLES`, 6: clocks per SRAM word access. Legal range ≥ 2.
- `ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 16: SRAM data width. Line width is 4×`DATA_W`.

Ports. One clock; reset is synchronous and active-low.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset. `rst`=0 at a rising edge resets the block.
- `req_valid` in 1: request strobe from `cache_controller`.
- `req_we` in 1: 1 = word write, 0 = line read.
- `req_addr` in `ADDR_W`: word address. For reads, bits [1:0] are ignored and the line base is used.
- `req_wdata` in `DATA_W`: store data.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `line_data` out 4×`DATA_W`: refilled line. Word k is at [16k+15:16k].
- `SRAM_ADDR` out `ADDR_W`: SRAM address.
- `SRAM_DQ` inout `DATA_W`: SRAM data bus.
- `SRAM_UB_N_O`, `SRAM_LB_N_O`, `SRAM_WE_N_O`, `SRAM_CE_N_O`, `SRAM_OE_N_O` out 1 each: active-low SRAM strobes.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **IDLE**
  - `req_valid`=1 and `req_we`=0 → RD. Latch `{req_addr[ADDR_W-1:2],2'b00}`, word index k=0, cycle counter c=0.
  - `req_valid`=1 and `req_we`=1 → WR. Latch `req_addr` and `req_wdata`, c=0.
  - A simultaneous strobe takes exactly one path, selected by `req_we`.
- **RD**
  - `SRAM_ADDR` = base+k. `OE_N`=0, `CE_N`=0, `UB_N`=0, `LB_N`=0, `WE_N`=1. `DQ` tri-stated.
  - On the edge where c=`ACCESS_CYCLES`-1: capture `SRAM_DQ` into word k of the line buffer, set c=0, increment k.
  - After word 3 is captured → DONE.
  - Address increments are 2-bit local within the line: base+3 never carries beyond the line.
- **WR**
  - `SRAM_ADDR` = latched address. `CE_N`, `UB_N`, `LB_N` = 0. `OE_N`=1.
  - `DQ` driven with latched data for all `ACCESS_CYCLES` cycles.
  - `WE_N`=0 while c < `ACCESS_CYCLES`-1, and 1 on the final cycle, giving one cycle of data hold after the `WE_N` rising edge.
  - On the edge where c=`ACCESS_CYCLES`-1 → DONE. `line_data` is unchanged.
- **DONE**
  - `done`=1 and `busy`=1. All strobes deasserted, `DQ` tri-stated.
  - Next state: IDLE unconditionally.
- **Requests outside IDLE:** `req_valid` in RD, WR or DONE is ignored. `cache_controller` must hold its request until `done`; it is not queued here.
- **`line_data`:** changes only when a word is captured. Holds its last value until the next refill.
- **`SRAM_DQ` drive:** driven by this block only in WR. `z` at all other times, including reset.

## Timing
- **Reset values:**
  - state IDLE, `busy`=0, `done`=0, `line_data`=0, `SRAM_ADDR`=0;
  - all five strobes = 1;
  - `SRAM_DQ`=z, c=0, k=0.
- **Reset mid-operation:** an access in progress is aborted with no `done` pulse. Strobes return high on the reset edge. The partial `line_data` is cleared to 0.
- **Read latency:** accept edge at t0; `done`=1 in cycle t0+4·`ACCESS_CYCLES`+1. Default: 25 cycles.
- **Write latency:** `done`=1 in cycle t0+`ACCESS_CYCLES`+1. Default: 7 cycles.
- **Back-to-back requests:** the earliest next acceptance is the IDLE cycle following DONE. Minimum gap between `done` pulses = latency+1.
- **Read capture:** each word is sampled on its last access cycle, which is `ACCESS_CYCLES`-1 cycles after the address became stable.

## Structure
- **Shared package (`sram_pkg`):**
  - state encoding (2-bit enum: IDLE, RD, WR, DONE);
  - `LINE_WORDS`=4;
  - `SRAM_ADDR_W`=18;
  - default `ACCESS_CYCLES`=6.
- **Sub-module `sram_wait_counter`:** clears on state entry, asserts `last` when c=`ACCESS_CYCLES`-1. It is reused by the instruction-side loader.
- **Top level:** FSM, line buffer and pin drivers.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `req_valid`=1 → all strobes 1, `DQ`=z, `busy`=0, `done`=0, `line_data`=0.
- **Line read:** model returns mem[a]=16'hA000+a; read at `req_addr`=18'h00106 → addresses 104, 105, 106, 107 each held 6 cycles; `line_data`=64'hA107_A106_A105_A104; `done` at cycle 25.
- **Word write:** write 16'hBEEF to 18'h00010 → `WE_N` low for 5 cycles, then high for 1 with `DQ`=BEEF throughout; `done` at cycle 7; a subsequent read of line 18'h00010 returns word0=BEEF.
- **Back-to-back with stray strobe:** write then read issued on the cycle after DONE → second request accepted; a `req_valid` pulse during RD is ignored and produces exactly 2 `done` pulses.
- **Reset mid-read:** assert `rst`=0 at cycle 10 of a read → no `done`, `line_data`=0, IDLE next cycle; a new read completes normally.
- **Short access:** with `ACCESS_CYCLES`=2 → read `done` at cycle 9, write `done` at cycle 3, `WE_N` low exactly 1 cycle.
